// File: rtl/button_event_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_encoder_pkg
//  Description : Shared constants for the button event encoder: button count,
//                arbitration order indices and last_event codes.
//  Revision    : 1.0  initial release
// ============================================================================
package button_event_encoder_pkg;

    localparam int NUM_BTN = 5;
    localparam int EV_W    = 3;

    // Bit positions in the internal button vectors; lower index wins arbitration.
    localparam int BTN_IDX_1  = 0;
    localparam int BTN_IDX_2  = 1;
    localparam int BTN_IDX_3  = 2;
    localparam int BTN_IDX_4  = 3;
    localparam int BTN_IDX_10 = 4;

    // Codes reported on last_event.
    localparam logic [EV_W-1:0] EV_NONE = 3'd0;
    localparam logic [EV_W-1:0] EV_1    = 3'd1;
    localparam logic [EV_W-1:0] EV_2    = 3'd2;
    localparam logic [EV_W-1:0] EV_3    = 3'd3;
    localparam logic [EV_W-1:0] EV_4    = 3'd4;
    localparam logic [EV_W-1:0] EV_10   = 3'd5;

    // Button index i maps to code i+1, so button 10 (index 4) reports 5.
    function automatic logic [EV_W-1:0] onehot_to_code(input logic [NUM_BTN-1:0] oh);
        logic [EV_W-1:0] code;
        code = EV_NONE;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (oh[i]) begin
                code = EV_W'(i + 1);
            end
        end
        return code;
    endfunction

endpackage : button_event_encoder_pkg
`default_nettype wire

// File: rtl/button_event_encoder_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One button channel: 2-flop synchronizer, counter-based
//                debouncer and rising-edge press detector on the debounced
//                level.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer for the raw pad level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the stable level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

    // Delayed copy of the stable level for press (0->1) detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    // Press is high for the one cycle following an accepted rising level.
    assign o_press = r_stable & ~r_stable_d;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_encoder
//  Description : Debounces five buttons, queues accepted presses as pending
//                flags and issues one single-cycle event pulse per press in
//                fixed priority order (1,2,3,4,10).
//  Revision    : 1.0  initial release
// ============================================================================
module button_event_encoder
    import button_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            btn_1,
    input  logic            btn_2,
    input  logic            btn_3,
    input  logic            btn_4,
    input  logic            btn_10,
    output logic            event_1,
    output logic            event_2,
    output logic            event_3,
    output logic            event_4,
    output logic            event_10,
    output logic [EV_W-1:0] last_event,
    output logic            pending_any
);

    localparam logic [NUM_BTN-1:0] C_ONE = NUM_BTN'(1);

    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_grant;
    logic [NUM_BTN-1:0] w_pending_next;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_grant;
    logic [NUM_BTN-1:0] r_event;
    logic [EV_W-1:0]    r_last_event;
    logic               r_pending_any;

    assign w_btn[BTN_IDX_1]  = btn_1;
    assign w_btn[BTN_IDX_2]  = btn_2;
    assign w_btn[BTN_IDX_3]  = btn_3;
    assign w_btn[BTN_IDX_4]  = btn_4;
    assign w_btn[BTN_IDX_10] = btn_10;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk     (CLK),
                .rst     (RST),
                .i_btn   (w_btn[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    // Lowest set bit of the pending vector wins (two's-complement isolate).
    assign w_grant = r_pending & (~r_pending + C_ONE);

    // Granted flag clears while new presses set; a press on the granted
    // button itself re-arms it, and presses on other buttons are never lost.
    assign w_pending_next = (r_pending & ~w_grant) | w_press;

    // Pending flags, registered grant and pending_any summary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pending     <= '0;
            r_grant       <= '0;
            r_pending_any <= 1'b0;
        end else begin
            r_pending     <= w_pending_next;
            r_grant       <= w_grant;
            r_pending_any <= |w_pending_next;
        end
    end

    // Event pulses follow the registered grant; last_event tracks each pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_event      <= '0;
            r_last_event <= EV_NONE;
        end else begin
            r_event <= r_grant;
            if (|r_grant) begin
                r_last_event <= onehot_to_code(r_grant);
            end
        end
    end

    assign event_1     = r_event[BTN_IDX_1];
    assign event_2     = r_event[BTN_IDX_2];
    assign event_3     = r_event[BTN_IDX_3];
    assign event_4     = r_event[BTN_IDX_4];
    assign event_10    = r_event[BTN_IDX_10];
    assign last_event  = r_last_event;
    assign pending_any = r_pending_any;

endmodule : button_event_encoder
`default_nettype wire

// File: doc/button_event_encoder.md
BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized cycles a level change must persist before it is accepted; legal range 2..2^20.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous assert, active-high.
REQ-004 btn_1, btn_2, btn_3, btn_4, btn_10  input  1 each  raw, asynchronous, bouncing pad levels; 1 = pressed.
REQ-005 event_1, event_2, event_3, event_4, event_10  output  1 each  registered single-cycle press pulses for the LED event pattern blocks' button_inp.
REQ-006 last_event  output  3  registered code of the most recent pulse: 0 none, 1..4 = event_1..event_4, 5 = event_10.
REQ-007 pending_any  output  1  registered; high while any press is waiting for arbitration.

Function
REQ-008 Each btn_* SHALL pass a 2-flop synchronizer before any other logic.
REQ-009 Each button SHALL hold a debounced level (stable) and a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-010 Synchronized level == stable: counter SHALL clear to 0.
REQ-011 Synchronized level != stable: counter SHALL increment; on the edge where it reaches DEBOUNCE_CYCLES-1, stable SHALL take the synchronized level and the counter SHALL clear.
REQ-012 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave stable unchanged and generate no event.
REQ-013 Each stable 0->1 transition SHALL set that button's pending flag on the following edge; 1->0 transitions SHALL generate nothing.
REQ-014 A held button SHALL generate exactly one event per accepted press, with no auto-repeat.
REQ-015 A press accepted while its own pending flag is already set SHALL coalesce into that flag; no extra event.
REQ-016 Arbiter: each cycle with any pending flag set, the lowest-order pending button (order 1,2,3,4,10) SHALL be granted, its flag cleared, and its event output asserted high for exactly the next cycle.
REQ-017 At most one event output SHALL be high in any cycle.
REQ-018 All event outputs SHALL be low in every cycle without a grant.
REQ-019 A flag set on the same edge as its grant-clear for a different button SHALL be retained.
REQ-020 last_event SHALL update on the same edge as the corresponding pulse and hold until the next pulse.
REQ-021 Latency, isolated press, nothing else pending: event pulse high in the cycle starting DEBOUNCE_CYCLES+4 rising edges after the first edge sampling btn high.
REQ-022 Simultaneous accepted presses on k buttons SHALL produce k pulses on k consecutive cycles in arbitration order.

Reset
REQ-023 RST high SHALL asynchronously clear synchronizers, stable levels, counters, pending flags, event outputs, last_event and pending_any to 0.
REQ-024 A button held high across reset release SHALL be debounced from stable=0 and SHALL produce exactly one event.
REQ-025 RST asserted mid-debounce or mid-arbitration SHALL discard all in-flight presses; no pulse SHALL appear after release for presses seen before reset.

Structure
REQ-026 A shared package SHALL hold NUM_BTN=5, the button-order index constants and the last_event code constants (EV_NONE=0 .. EV_10=5).
REQ-027 Per-button synchronizer+debouncer+press detect SHALL be a sub-module btn_debounce, instantiated five times; arbitration and output registers stay in the top.

Verification
REQ-028 Clean press, btn_2 high 40 cycles, DEBOUNCE_CYCLES=16 -> single event_2 pulse 20 edges after first sample, last_event=2, no pulse on release.
REQ-029 btn_1 bouncing with pulses of 3, 5 and 15 cycles, then held 30 -> no pulse during bounce, exactly one event_1 pulse.
REQ-030 btn_1, btn_3, btn_10 rise on the same cycle -> event_1, event_3, event_10 pulses on three consecutive cycles, last_event ends at 5, pending_any low after.
REQ-031 btn_4 held 200 cycles -> exactly one event_4 pulse; no other output activity.
REQ-032 RST pulsed 8 cycles after btn_2 rises -> all outputs 0 immediately, no event_2 afterwards while btn_2 released before reset release.
REQ-033 btn_10 held through reset release -> one event_10 pulse DEBOUNCE_CYCLES+4 edges after release.
